// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO: 33 busy cycles per op, done pulses after the write.
// No backpressure: start/MTHI/MTLO are only honoured in IDLE; the core stalls on o_busy.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_div;
    logic             r_done;

    logic             w_op_sgn;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH:0]   w_madd;
    logic [2*WIDTH:0] w_mul_next;
    logic [2*WIDTH:0] w_dsh;
    logic             w_dge;
    logic [WIDTH:0]   w_dsub;
    logic [2*WIDTH:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_op_sgn = (i_funct == F_MULT) || (i_funct == F_DIV);
    assign w_rs_neg = w_op_sgn & i_rs[WIDTH-1];
    assign w_rt_neg = w_op_sgn & i_rt[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -i_rs : i_rs;
    assign w_rt_mag = w_rt_neg ? -i_rt : i_rt;

    // Multiply: multiplier is r_b, consumed LSB first; product bits enter from the top.
    assign w_madd     = r_acc[2*WIDTH:WIDTH] + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
    assign w_mul_next = {w_madd, r_acc[WIDTH-1:0]} >> 1;

    // Divide: r_acc holds {remainder, quotient}; remainder stays below the divisor.
    assign w_dsh      = {r_acc[2*WIDTH-1:0], 1'b0};
    assign w_dge      = w_dsh[2*WIDTH:WIDTH] >= {1'b0, r_b};
    assign w_dsub     = w_dsh[2*WIDTH:WIDTH] - {1'b0, r_b};
    assign w_div_next = w_dge ? {w_dsub, w_dsh[WIDTH-1:1], 1'b1} : w_dsh;

    // A zero divisor yields an all-ones quotient and the dividend as remainder.
    assign w_prod_fix = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    assign w_quo_fix  = (r_b == '0) ? {WIDTH{1'b1}}
                      : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        case (i_funct)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                r_a      <= w_rs_mag;
                                r_b      <= w_rt_mag;
                                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                                r_neg_r  <= w_rs_neg;
                                r_is_div <= i_funct[1];
                                r_acc    <= i_funct[1] ? {{(WIDTH+1){1'b0}}, w_rs_mag} : '0;
                                r_cnt    <= '0;
                                r_state  <= S_RUN;
                            end
                            F_MTHI:  r_hi <= i_rs;
                            F_MTLO:  r_lo <= i_rs;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (!r_is_div) begin
                        r_b <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed table, hand-written corner sequences and random ops vs. an arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] rs = 32'h0;
    logic [31:0] rt = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[10];

    muldiv_seq #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_funct (funct),
        .i_rs    (rs),
        .i_rt    (rt),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'h0;
        l = 32'h0;
        case (f)
            6'h18: begin
                p = sa * sb;
                {h, l} = p;
            end
            6'h19: begin
                p = {32'h0, a} * {32'h0, b};
                {h, l} = p;
            end
            6'h1a: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            6'h1b: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issues an op at the current negedge and waits for completion; inj pokes ignored requests mid-run.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name,
                          input bit inj);
        int   n;
        logic held;
        funct = f;
        rs    = a;
        rt    = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
        n     = 0;
        held  = 1'b1;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (inj && n == 10) begin
                funct = 6'h1b;
                rs    = 32'h5;
                rt    = 32'h1;
                start = 1'b1;
            end
            if (inj && n == 11) begin
                funct = 6'h11;
                rs    = 32'hAAAA;
            end
            if (inj && n == 12) start = 1'b0;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 32'(n), 32'd33);
        chk({name, " hilo_held"}, 32'(held), 32'd1);
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v, input string name);
        funct = f;
        rs    = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (f == 6'h11) m_hi = v;
        if (f == 6'h13) m_lo = v;
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " hi"}, hi, m_hi);
        chk({name, " lo"}, lo, m_lo);
        @(negedge clk);
        chk({name, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          kind;

        tbl[0] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2] = '{6'h1a, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[4] = '{6'h1b, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        tbl[5] = '{6'h1a, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[6] = '{6'h1a, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        tbl[7] = '{6'h1a, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        tbl[8] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[9] = '{6'h19, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        #3;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Requests during a run are dropped; MTLO in the done cycle is accepted.
        run_op(6'h19, 32'd3, 32'd4, 32'd0, 32'd12, "ignore_multu", 1'b1);
        mt(6'h13, 32'h55, "mtlo_in_done");
        mt(6'h11, 32'hDEAD_BEEF, "mthi");

        funct = 6'h20;
        rs    = 32'h1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_funct busy", 32'(busy), 32'd0);
        chk("bad_funct hi", hi, m_hi);
        chk("bad_funct lo", lo, m_lo);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].h, tbl[i].l, $sformatf("tbl%0d", i), 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                mt(6'h11, $urandom, $sformatf("rnd%0d_mthi", i));
            end else if (kind == 1) begin
                mt(6'h13, $urandom, $sformatf("rnd%0d_mtlo", i));
            end else begin
                f = 6'h18 + 6'($urandom_range(0, 3));
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 7))
                    0: b = 32'h0;
                    1: b = 32'($urandom_range(1, 15));
                    2: a = 32'h80000000;
                    3: b = 32'hFFFFFFFF;
                    default: ;
                endcase
                model(f, a, b, eh, el);
                run_op(f, a, b, eh, el, $sformatf("rnd%0d", i), 1'b0);
            end
        end

        // Reset mid-division aborts with no partial write.
        mt(6'h11, 32'hCAFE_0001, "pre_abort_mthi");
        funct = 6'h1a;
        rs    = 32'd100;
        rt    = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(6'h1a, 32'd100, 32'd7, 32'd2, 32'd14, "post_abort_div", 1'b0);
        @(negedge clk);
        chk("post_abort done_drop", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
